// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding logic.
// Pure declarations: no latency, no flow control.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM_WAIT  = 2'd1,
        ST_CSR_DRAIN = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    // x0 is hardwired to zero, so it never counts as a register match
    function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// ALU operand forwarding select for one source register; M beats W.
// Purely combinational, zero latency; never stalls.
module fwd_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] i_ra,
    input  logic [4:0] i_rd_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_reg_write_m,
    input  logic       i_reg_write_w,
    output logic [1:0] o_fwd_sel
);

    always_comb begin
        o_fwd_sel = FWD_RF;
        if (i_reg_write_m && reg_hit(i_rd_m, i_ra)) begin
            o_fwd_sel = FWD_MEM;
        end else if (i_reg_write_w && reg_hit(i_rd_w, i_ra)) begin
            o_fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls/flushes for load-use, branch, CSR drain and memory wait, plus forwarding.
// Stall/flush outputs are combinational from state and inputs; a memory wait holds every stage until mem_ready.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT   = 255,
    parameter int CSR_DRAIN = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [4:0] Ra1D,
    input  logic [4:0] Ra2D,
    input  logic [4:0] Ra1E,
    input  logic [4:0] Ra2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic       csrE,
    input  logic       MemReqM,
    input  logic       mem_ready,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       enDE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       mem_timeout
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [7:0] DRAIN_C   = 8'(CSR_DRAIN);

    hz_state_t  r_state;
    hz_state_t  w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;
    logic [7:0] r_drain_cnt;
    logic [7:0] w_drain_cnt_nxt;
    logic       r_mem_timeout;
    logic       w_timeout_hit;
    logic       w_run_like;
    logic       w_mem_wait;
    logic       w_load_use;
    logic       w_stall_f;
    logic       w_stall_d;
    logic       w_stall_e;
    logic       w_stall_m;
    logic       w_flush_d;
    logic       w_flush_e;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_mem_wait = MemReqM & ~mem_ready;
    assign w_load_use = (ResultSrcE == RESULT_LOAD) &
                        (reg_hit(RdE, Ra1D) | reg_hit(RdE, Ra2D));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_drain_cnt   <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            if (w_timeout_hit) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = 8'd0;
        w_drain_cnt_nxt = r_drain_cnt;
        w_timeout_hit   = 1'b0;
        w_run_like      = 1'b0;
        w_stall_f       = 1'b0;
        w_stall_d       = 1'b0;
        w_stall_e       = 1'b0;
        w_stall_m       = 1'b0;
        w_flush_d       = 1'b0;
        w_flush_e       = 1'b0;

        case (r_state)
            ST_MEM_WAIT: begin
                // The ready cycle lets the pipe advance, so hazards are decoded as in RUN
                if (mem_ready) begin
                    w_run_like = 1'b1;
                end else begin
                    {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
                    w_wait_cnt_nxt = (r_wait_cnt == TIMEOUT_C) ? r_wait_cnt
                                                               : r_wait_cnt + 8'd1;
                    w_timeout_hit  = (w_wait_cnt_nxt == TIMEOUT_C);
                end
            end
            ST_CSR_DRAIN: begin
                if (w_mem_wait) begin
                    {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
                    w_state_nxt     = ST_MEM_WAIT;
                    w_drain_cnt_nxt = 8'd0;
                end else begin
                    w_stall_f       = 1'b1;
                    w_stall_d       = 1'b1;
                    w_flush_e       = 1'b1;
                    w_drain_cnt_nxt = (r_drain_cnt == 8'd0) ? 8'd0 : r_drain_cnt - 8'd1;
                    if (r_drain_cnt <= 8'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: w_run_like = 1'b1;
        endcase

        if (w_run_like) begin
            w_state_nxt = ST_RUN;
            if (w_mem_wait) begin
                {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
                w_state_nxt = ST_MEM_WAIT;
            end else if (PCSrcE) begin
                w_flush_d = 1'b1;
                w_flush_e = 1'b1;
            end else if (w_load_use) begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_flush_e = 1'b1;
            end else if (csrE) begin
                w_state_nxt     = ST_CSR_DRAIN;
                w_drain_cnt_nxt = DRAIN_C;
            end
        end
    end

    fwd_unit u_fwd_a (
        .i_ra          (Ra1E),
        .i_rd_m        (RdM),
        .i_rd_w        (RdW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_fwd_sel     (w_fwd_a)
    );

    fwd_unit u_fwd_b (
        .i_ra          (Ra2E),
        .i_rd_m        (RdM),
        .i_rd_w        (RdW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_fwd_sel     (w_fwd_b)
    );

    // Reset holds the pipe in a flushed, non-stalled, non-forwarding state
    assign StallF      = n_rst & w_stall_f;
    assign StallD      = n_rst & w_stall_d;
    assign StallE      = n_rst & w_stall_e;
    assign StallM      = n_rst & w_stall_m;
    assign FlushD      = ~n_rst | w_flush_d;
    assign FlushE      = ~n_rst | w_flush_e;
    assign enDE        = ~StallE;
    assign ForwardAE   = n_rst ? w_fwd_a : FWD_RF;
    assign ForwardBE   = n_rst ? w_fwd_b : FWD_RF;
    assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations, then randomized traffic vs a behavioural model.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    localparam int TB_TIMEOUT = 4;
    localparam int TB_DRAIN   = 2;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [4:0] Ra1D = '0, Ra2D = '0, Ra1E = '0, Ra2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic       RegWriteM = 1'b0, RegWriteW = 1'b0;
    logic [1:0] ResultSrcE = '0;
    logic       PCSrcE = 1'b0, csrE = 1'b0, MemReqM = 1'b0, mem_ready = 1'b0;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, enDE, mem_timeout;
    logic [1:0] ForwardAE, ForwardBE;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(.TIMEOUT(TB_TIMEOUT), .CSR_DRAIN(TB_DRAIN)) dut (
        .clk(clk), .n_rst(n_rst),
        .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .csrE(csrE),
        .MemReqM(MemReqM), .mem_ready(mem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .enDE(enDE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural model: is a memory access outstanding, how many drain cycles remain,
    // how long the current memory wait has lasted, and the sticky timeout flag.
    bit m_waiting     = 1'b0;
    int m_drain_left  = 0;
    int m_wait_cycles = 0;
    bit m_timeout     = 1'b0;

    function automatic bit f_mw();
        return MemReqM && !mem_ready;
    endfunction

    function automatic bit f_lu();
        return (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Ra1D) || (RdE == Ra2D));
    endfunction

    function automatic logic [1:0] fwd_of(input logic [4:0] ra);
        if (RegWriteM && RdM != 5'd0 && RdM == ra) return 2'b10;
        if (RegWriteW && RdW != 5'd0 && RdW == ra) return 2'b01;
        return 2'b00;
    endfunction

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,enDE,ForwardAE,ForwardBE,mem_timeout}
    function automatic logic [11:0] model_outs();
        logic [3:0] st;
        logic       fd, fe;
        st = 4'b0000; fd = 1'b0; fe = 1'b0;
        if (!n_rst) return {4'b0000, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0};
        if (m_waiting && !mem_ready) begin
            st = 4'b1111;
        end else if (m_drain_left > 0) begin
            if (f_mw()) st = 4'b1111;
            else begin st = 4'b1100; fe = 1'b1; end
        end else if (f_mw()) begin
            st = 4'b1111;
        end else if (PCSrcE) begin
            fd = 1'b1; fe = 1'b1;
        end else if (f_lu()) begin
            st = 4'b1100; fe = 1'b1;
        end
        return {st, fd, fe, ~st[1], fwd_of(Ra1E), fwd_of(Ra2E), m_timeout};
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_waiting     <= 1'b0;
            m_drain_left  <= 0;
            m_wait_cycles <= 0;
            m_timeout     <= 1'b0;
        end else if (m_waiting && !mem_ready) begin
            m_wait_cycles <= (m_wait_cycles + 1 > TB_TIMEOUT) ? TB_TIMEOUT : m_wait_cycles + 1;
            if (m_wait_cycles + 1 >= TB_TIMEOUT) m_timeout <= 1'b1;
        end else if (m_drain_left > 0) begin
            m_wait_cycles <= 0;
            if (f_mw()) begin
                m_waiting    <= 1'b1;
                m_drain_left <= 0;
            end else begin
                m_drain_left <= m_drain_left - 1;
            end
        end else begin
            m_wait_cycles <= 0;
            m_waiting     <= f_mw();
            if (!f_mw() && !PCSrcE && !f_lu() && csrE) m_drain_left <= TB_DRAIN;
        end
    end

    always @(negedge clk) begin
        logic [11:0] g_vec, e_vec;
        g_vec = {StallF, StallD, StallE, StallM, FlushD, FlushE, enDE, ForwardAE, ForwardBE, mem_timeout};
        e_vec = model_outs();
        n_cmp = n_cmp + 1;
        if (g_vec !== e_vec) begin
            n_bad = n_bad + 1;
            $display("FAIL outs t=%0t got=%b want=%b", $time, g_vec, e_vec);
        end
    end

    task automatic lit(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp = n_cmp + 1;
        if (got !== want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Ra1D = '0; Ra2D = '0; Ra1E = '0; Ra2E = '0; RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = '0;
        PCSrcE = 1'b0; csrE = 1'b0; MemReqM = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #3;
        lit("rst_stalls", 8'({StallF, StallD, StallE, StallM}), 8'h0);
        lit("rst_flushes", 8'({FlushD, FlushE, enDE}), 8'h7);
        RegWriteM = 1'b1; RdM = 5'd3; Ra1E = 5'd3; Ra2E = 5'd3;
        #1;
        lit("rst_fwd", 8'({ForwardAE, ForwardBE, mem_timeout}), 8'h0);
        tick(); idle(); n_rst = 1'b1;

        // load-use, one cycle only
        tick(); RdE = 5'd5; ResultSrcE = 2'b01; Ra1D = 5'd5; #2;
        lit("lu_stall", 8'({StallF, StallD, FlushE, enDE}), 8'hF);
        lit("lu_no_hold_e", 8'({FlushD, StallE, StallM}), 8'h0);
        tick(); ResultSrcE = 2'b00; #2;
        lit("lu_released", 8'({StallF, StallD, FlushE}), 8'h0);

        // branch beats load-use
        tick(); ResultSrcE = 2'b01; PCSrcE = 1'b1; #2;
        lit("br_over_lu", 8'({FlushD, FlushE, StallF, StallD}), 8'hC);

        // short memory wait
        for (int k = 0; k < 3; k++) begin
            tick(); idle(); MemReqM = 1'b1; #2;
            lit("memwait_stall", 8'({StallF, StallD, StallE, StallM, FlushD, FlushE}), 8'h3C);
        end
        tick(); mem_ready = 1'b1; #2;
        lit("memready_release", 8'({StallF, StallD, StallE, StallM}), 8'h0);
        tick(); idle(); RdE = 5'd5; ResultSrcE = 2'b01; Ra2D = 5'd5; #2;
        lit("after_mem_in_run", 8'({StallF, StallD, StallE, FlushE}), 8'hD);
        lit("no_timeout_short", 8'(mem_timeout), 8'h0);

        // timeout after four wait cycles, sticky until reset
        tick(); idle(); MemReqM = 1'b1; #2;
        lit("to_enter", 8'(StallM), 8'h1);
        for (int k = 1; k <= 4; k++) begin
            tick(); #2;
            lit("to_pending", 8'(mem_timeout), 8'h0);
        end
        tick(); #2;
        lit("to_set", 8'({mem_timeout, StallF}), 8'h3);
        tick(); mem_ready = 1'b1; #2;
        lit("to_ready", 8'({mem_timeout, StallF}), 8'h2);
        repeat (3) begin tick(); idle(); end
        #2;
        lit("to_sticky", 8'(mem_timeout), 8'h1);
        tick(); n_rst = 1'b0; #2;
        lit("to_cleared", 8'(mem_timeout), 8'h0);
        tick(); n_rst = 1'b1;

        // CSR drain, then drain abandoned by a memory wait
        tick(); csrE = 1'b1; #2;
        lit("csr_entry", 8'({StallF, FlushE}), 8'h0);
        tick(); csrE = 1'b0; #2;
        lit("csr_drain1", 8'({StallF, StallD, FlushE, StallE}), 8'hE);
        tick(); #2;
        lit("csr_drain2", 8'({StallF, StallD, FlushE, StallE}), 8'hE);
        tick(); #2;
        lit("csr_done", 8'({StallF, StallD, FlushE}), 8'h0);
        tick(); csrE = 1'b1;
        tick(); csrE = 1'b0; MemReqM = 1'b1; #2;
        lit("csr_memwait", 8'({StallF, StallD, StallE, StallM, FlushE}), 8'h1E);
        tick(); mem_ready = 1'b1; #2;
        lit("csr_wait_ready", 8'({StallF, StallE}), 8'h0);
        tick(); idle(); #2;
        lit("csr_no_resume", 8'({StallF, StallD, FlushE}), 8'h0);

        // forwarding
        tick(); RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd7; RdW = 5'd7; Ra1E = 5'd7; #2;
        lit("fwdA_mem_wins", 8'(ForwardAE), 8'h2);
        tick(); RdM = 5'd0; #2;
        lit("fwdA_wb", 8'(ForwardAE), 8'h1);
        tick(); Ra1E = 5'd0; RdW = 5'd0; #2;
        lit("fwdA_x0", 8'(ForwardAE), 8'h0);
        tick(); RegWriteM = 1'b0; RdM = 5'd9; RdW = 5'd9; Ra2E = 5'd9; #2;
        lit("fwdB_wb", 8'(ForwardBE), 8'h1);

        // reset in the middle of a memory wait
        tick(); idle(); MemReqM = 1'b1;
        tick(); #2;
        lit("rst_mid_pre", 8'(StallE), 8'h1);
        n_rst = 1'b0; #1;
        lit("rst_mid_outs", 8'({StallF, StallE, FlushD, FlushE}), 8'h3);
        tick(); idle(); n_rst = 1'b1;
        tick(); #2;
        lit("rst_mid_resume", 8'({StallF, StallE}), 8'h0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick();
            Ra1D = 5'($urandom_range(0, 7));
            Ra2D = 5'($urandom_range(0, 7));
            Ra1E = 5'($urandom_range(0, 7));
            Ra2E = 5'($urandom_range(0, 7));
            RdE  = 5'($urandom_range(0, 7));
            RdM  = 5'($urandom_range(0, 7));
            RdW  = 5'($urandom_range(0, 7));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE     = ($urandom_range(0, 7) == 0);
            csrE       = ($urandom_range(0, 7) == 0);
            MemReqM    = ($urandom_range(0, 3) == 0);
            mem_ready  = (i >= 2000 && i < 2600) ? ($urandom_range(0, 7) == 0)
                                                 : ($urandom_range(0, 3) != 0);
            n_rst      = ($urandom_range(0, 299) != 0);
        end

        tick(); idle(); n_rst = 1'b1;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 255, the memory-wait cycle count at which mem_timeout sets.
REQ-002 The module SHALL have parameter CSR_DRAIN, default 2, the number of drain cycles after a CSR instruction reaches E.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port n_rst, input, 1, reset; asynchronous, active-low.
REQ-005 The module SHALL have ports Ra1D/Ra2D, input, 5 each, source registers of the instruction in D.
REQ-006 The module SHALL have ports Ra1E/Ra2E/RdE, input, 5 each, source and destination registers in E.
REQ-007 The module SHALL have ports RdM/RdW, input, 5 each, destination registers in M and W.
REQ-008 The module SHALL have ports RegWriteM/RegWriteW, input, 1 each, register-write enables in M and W.
REQ-009 The module SHALL have port ResultSrcE, input, 2, where 2'b01 marks a load in E.
REQ-010 The module SHALL have port PCSrcE, input, 1, taken branch or jump resolved in E.
REQ-011 The module SHALL have port csrE, input, 1, CSR instruction in E.
REQ-012 The module SHALL have ports MemReqM/mem_ready, input, 1 each, the data-memory request in M and the asynchronous memory's completion.
REQ-013 The module SHALL have ports StallF/StallD/StallE/StallM, output, 1 each, hold the PC and the D, E and M registers.
REQ-014 The module SHALL have ports FlushD/FlushE, output, 1 each, bubble the D register and the DE register (DE clr).
REQ-015 The module SHALL have port enDE, output, 1, DE register enable, always equal to ~StallE.
REQ-016 The module SHALL have ports ForwardAE/ForwardBE, output, 2 each, ALU operand select: 00 register file, 01 W, 10 M.
REQ-017 The module SHALL have port mem_timeout, output, 1, a sticky memory-wait timeout flag.

Function
REQ-018 The FSM SHALL have states RUN, MEM_WAIT and CSR_DRAIN, with a 2-bit state register.
REQ-019 A load-use hazard SHALL be detected as ResultSrcE==01, RdE!=0 and RdE equal to Ra1D or Ra2D.
REQ-020 In RUN, a load-use hazard SHALL assert StallF, StallD and FlushE in the same cycle for exactly one cycle, with no state change.
REQ-021 In RUN, PCSrcE SHALL assert FlushD and FlushE and suppress any load-use stall in the same cycle.
REQ-022 In RUN, MemReqM & ~mem_ready SHALL assert StallF, StallD, StallE and StallM with no flushes, and the next state SHALL be MEM_WAIT.
REQ-023 The memory-wait condition SHALL have priority over branch flush, which SHALL have priority over load-use, which SHALL have priority over CSR entry.
REQ-024 In MEM_WAIT, all four stalls SHALL stay asserted and both flushes deasserted until mem_ready=1.
REQ-025 In the cycle mem_ready=1, MEM_WAIT stalls SHALL deassert combinationally and the next state SHALL be RUN.
REQ-026 wait_cnt SHALL be 8 bits, SHALL increment each MEM_WAIT cycle, and SHALL saturate at TIMEOUT.
REQ-027 When wait_cnt reaches TIMEOUT, mem_timeout SHALL set; wait_cnt SHALL clear on leaving MEM_WAIT, and mem_timeout SHALL clear only on reset.
REQ-028 In RUN, csrE with no higher-priority event SHALL load drain_cnt=CSR_DRAIN and the next state SHALL be CSR_DRAIN.
REQ-029 In CSR_DRAIN, StallF, StallD and FlushE SHALL be asserted and drain_cnt SHALL decrement each cycle.
REQ-030 CSR_DRAIN SHALL return to RUN after the cycle in which drain_cnt==1.
REQ-031 If MemReqM & ~mem_ready occurs in CSR_DRAIN, the next state SHALL be MEM_WAIT and the drain SHALL be abandoned.
REQ-032 ForwardAE SHALL be 10 if RegWriteM, RdM!=0 and RdM==Ra1E; else 01 if RegWriteW, RdW!=0 and RdW==Ra1E; else 00.
REQ-033 ForwardBE SHALL use the same rule as REQ-032 applied to Ra2E; M SHALL win when M and W both match.
REQ-034 Register x0 SHALL never cause a stall or a forward.

Reset
REQ-035 While n_rst=0: state=RUN, wait_cnt=0, drain_cnt=0, mem_timeout=0.
REQ-036 While n_rst=0: all Stall*=0, FlushD=FlushE=1, enDE=1, ForwardAE=ForwardBE=00.
REQ-037 Reset asserted mid-MEM_WAIT or mid-CSR_DRAIN SHALL abandon the operation immediately; operation SHALL resume in RUN at the first clk edge after release.

Structure
REQ-038 Package pipeline_pkg SHALL hold the state enum hz_state_t, constants FWD_RF/FWD_WB/FWD_MEM, and RESULT_LOAD=2'b01.
REQ-039 Sub-module fwd_unit SHALL hold the combinational forwarding logic and be instantiated once per operand (A and B); the FSM and hazard decode SHALL live in hazard_ctrl.

Verification
REQ-040 Scenario: RdE=5, ResultSrcE=01, Ra1D=5 -> one cycle of StallF=StallD=FlushE=1, enDE=1; next cycle, with ResultSrcE=00, no stall.
REQ-041 Scenario: PCSrcE=1 together with the load-use condition -> FlushD=FlushE=1, StallF=StallD=0.
REQ-042 Scenario: MemReqM=1, mem_ready=0 for 3 cycles then 1 -> all stalls high for 3 cycles, low in the ready cycle, state RUN afterwards, mem_timeout=0.
REQ-043 Scenario: TIMEOUT=4, mem_ready held 0 -> mem_timeout rises after the 4th wait cycle and stays 1 after ready, until n_rst.
REQ-044 Scenario: csrE=1 pulse -> StallF/StallD/FlushE high for exactly 2 cycles; a memory wait injected in the 1st drain cycle -> MEM_WAIT, no resumed drain.
REQ-045 Scenario: RdM=RdW=Ra1E=7 with both RegWrite=1 -> ForwardAE=10; RdM=0 -> ForwardAE=01; Ra1E=0 -> ForwardAE=00.
